// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    WAIT_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int unsigned DEBOUNCE_10MS_100MHZ = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioner: synchronise, debounce, and derive edge pulses and a press-toggled level.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s2;
  logic             rise_nxt, fall_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (s2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_LOW;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
      if (rise_nxt) toggle <= ~toggle;
    end
  end

  // Counter resets whenever the candidate value is abandoned or committed,
  // so it never exceeds STABLE_CYCLES.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      ST_LOW: begin
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = ST_LOW;
        end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
          state_nxt = ST_HIGH;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = ST_HIGH;
        end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
          state_nxt = ST_LOW;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_LOW;
    endcase
  end

  always_comb begin
    db = (state == ST_HIGH) || (state == WAIT_LOW);
  end

endmodule
